instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 27 ++
 rtl/instr_pack.sv | 55 +++++
 rtl/instr_encoder.sv | 131 +++++++++++++
 tb/tb_instr_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - RV32I opcode constants and encoder word type
//
// Purpose : opcode constants and the NOP word used by the encoder and by the
//           decoder, plus the struct that travels through the encoder buffer.
// Ports   : none (package).
package instr_encoder_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // One buffered output word: encoding, byte address, illegal flag.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        illegal;
    } enc_word_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32I field packer
//
// Purpose : packs opcode, register fields and the compact immediate into a
//           32-bit RV32I word; unsupported opcodes become NOP + illegal.
// Ports   : i_op, i_func, i_op_2, i_rd, i_rs1, i_rs2, i_imm -> field inputs
//           o_instr   -> encoded word
//           o_illegal -> opcode was not supported
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_func,
    input  logic [6:0]  i_op_2,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [19:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_illegal
);

    always_comb begin
        o_instr   = NOP;
        o_illegal = 1'b0;
        case (i_op)
            OP_REG:
                o_instr = {i_op_2, i_rs2, i_rs1, i_func, i_rd, i_op};
            OP_LOAD, OP_JALR:
                o_instr = {i_imm[11:0], i_rs1, i_func, i_rd, i_op};
            OP_IMM: begin
                // Shift-immediates carry funct7 above a 5-bit shamt.
                if (i_func == 3'd1 || i_func == 3'd5)
                    o_instr = {i_op_2, i_imm[4:0], i_rs1, i_func, i_rd, i_op};
                else
                    o_instr = {i_imm[11:0], i_rs1, i_func, i_rd, i_op};
            end
            OP_STORE:
                o_instr = {i_imm[11:5], i_rs2, i_rs1, i_func, i_imm[4:0], i_op};
            // Branch/jump immediates arrive already shifted right by one.
            OP_BRANCH:
                o_instr = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_func,
                           i_imm[3:0], i_imm[10], i_op};
            OP_JAL:
                o_instr = {i_imm[19], i_imm[9:0], i_imm[10], i_imm[18:11],
                           i_rd, i_op};
            OP_LUI, OP_AUIPC:
                o_instr = {i_imm, i_rd, i_op};
            default: begin
                o_instr   = NOP;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with 2-entry output buffer
//
// Purpose : accepts instruction fields, encodes them through instr_pack,
//           tags each word with its byte address and buffers up to two
//           words toward the output handshake.
// Ports   : clk, rst_n (async active-low), flush (sync clear)
//           in_valid/in_ready + op, func, op_2, rd, rs1, rs2, imm -> input side
//           out_valid/out_ready, out_instr, out_addr, out_illegal -> output side
//           illegal_cnt -> saturating count of accepted illegal opcodes
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  op,
    input  logic [2:0]  func,
    input  logic [6:0]  op_2,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [19:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_illegal,
    output logic [7:0]  illegal_cnt
);

    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_seq;
    logic [7:0]        r_ill_cnt;
    logic              r_out_valid;
    logic              r_in_ready;
    enc_word_t         r_head;   // entry presented on the output
    enc_word_t         r_tail;   // second entry, valid only when count == 2

    logic [31:0] w_instr;
    logic        w_illegal;
    enc_word_t   w_word;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_count_nxt;

    instr_pack u_pack (
        .i_op     (op),
        .i_func   (func),
        .i_op_2   (op_2),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_imm    (imm),
        .o_instr  (w_instr),
        .o_illegal(w_illegal)
    );

    assign w_word.instr   = w_instr;
    assign w_word.addr    = BASE_ADDR + (32'(r_seq) << 2);
    assign w_word.illegal = w_illegal;

    // An input offered alongside flush is dropped.
    assign w_push = in_valid && r_in_ready && !flush;
    assign w_pop  = r_out_valid && out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 2'd0;
            r_seq       <= '0;
            r_ill_cnt   <= 8'd0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_head      <= '{instr: 32'd0, addr: BASE_ADDR, illegal: 1'b0};
            r_tail      <= '0;
        end else if (flush) begin
            // Buffered data regs keep their contents; out_valid hides them.
            r_count     <= 2'd0;
            r_seq       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_seq <= r_seq + ADDR_W'(1);
                if (w_illegal && r_ill_cnt != 8'hFF)
                    r_ill_cnt <= r_ill_cnt + 8'd1;
            end
            case (r_count)
                2'd0: begin
                    if (w_push)
                        r_head <= w_word;
                end
                2'd1: begin
                    // Push with pop replaces the head; push alone fills tail.
                    if (w_push && w_pop)
                        r_head <= w_word;
                    else if (w_push)
                        r_tail <= w_word;
                end
                default: begin
                    // in_ready is low at count 2, so only a pop can occur.
                    if (w_pop)
                        r_head <= r_tail;
                end
            endcase
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != 2'd0);
            r_in_ready  <= (w_count_nxt != 2'd2);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_head.instr;
    assign out_addr    = r_head.addr;
    assign out_illegal = r_head.illegal;
    assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    localparam int          ADDR_W = 2;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [2:0]  func;
    logic [6:0]  op_2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_illegal;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .func       (func),
        .op_2       (op_2),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [6:0] f_op, input logic [2:0] f_func,
                              input logic [6:0] f_op2, input logic [4:0] f_rd,
                              input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                              input logic [19:0] f_imm);
        op = f_op; func = f_func; op_2 = f_op2;
        rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; imm = f_imm;
    endtask

    // Present one input for a single cycle (in_ready assumed high).
    task automatic send_one(input logic [6:0] f_op, input logic [2:0] f_func,
                            input logic [6:0] f_op2, input logic [4:0] f_rd,
                            input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                            input logic [19:0] f_imm);
        set_fields(f_op, f_func, f_op2, f_rd, f_rs1, f_rs2, f_imm);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_addr, input logic e_ill);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, e_instr);
        chk({tag, "_addr"}, out_addr, e_addr);
        chk({tag, "_illegal"}, 32'(out_illegal), 32'(e_ill));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 20'h0);
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);

        rst_n = 1'b1;
        step();
        chk("first_edge_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back encodings; each word pops as the next one is pushed.
        out_ready = 1'b1;
        send_one(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h00005);
        chk_word("addi", 32'h0050_0093, BASE, 1'b0);
        send_one(7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 20'h00008);
        chk_word("sw", 32'h0020_A423, BASE + 32'd4, 1'b0);
        send_one(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 20'h00008);
        chk_word("beq", 32'h0020_8863, BASE + 32'd8, 1'b0);
        send_one(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h00004);
        chk_word("jal", 32'h0080_00EF, BASE + 32'd12, 1'b0);
        send_one(7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 20'hFFFFF);
        chk_word("illegal_wrap", 32'h0000_0013, BASE, 1'b1);
        chk("illegal_cnt_1", 32'(illegal_cnt), 32'd1);
        send_one(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 20'hABCDE);
        chk_word("sub", 32'h4020_81B3, BASE + 32'd4, 1'b0);
        send_one(7'h13, 3'd5, 7'h20, 5'd3, 5'd2, 5'd0, 20'hFFFE3);
        chk_word("srai", 32'h4031_5193, BASE + 32'd8, 1'b0);
        send_one(7'h37, 3'd7, 7'h7F, 5'd5, 5'd9, 5'd9, 20'h12345);
        chk_word("lui", 32'h1234_52B7, BASE + 32'd12, 1'b0);

        // Clear, then stall the output while three inputs are offered.
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h00005);
        step();
        set_fields(7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 20'h00008);
        step();
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        set_fields(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 20'h12345);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_word("stall_hold", 32'h0050_0093, BASE, 1'b0);
            chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_word("drain_2nd", 32'h0020_A423, BASE + 32'd4, 1'b0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Saturation of the illegal counter over a continuous stream.
        set_fields(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 20'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 253; i++) step();
        chk("illegal_cnt_254", 32'(illegal_cnt), 32'd254);
        for (int i = 0; i < 47; i++) step();
        in_valid = 1'b0;
        chk("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);
        step();
        step();

        // Flush with two words buffered and an input offered at the same time.
        out_ready = 1'b0;
        send_one(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h00005);
        send_one(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 20'h00006);
        set_fields(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 20'h0);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("midflush_out_valid", 32'(out_valid), 32'd0);
        chk("midflush_in_ready", 32'(in_ready), 32'd1);
        chk("midflush_illegal_cnt", 32'(illegal_cnt), 32'd255);
        out_ready = 1'b1;
        send_one(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 20'h12345);
        chk_word("post_flush", 32'h1234_52B7, BASE, 1'b0);
        step();

        // Asynchronous reset with two words buffered.
        out_ready = 1'b0;
        send_one(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h00004);
        send_one(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 20'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        chk("async_rst_addr", out_addr, BASE);
        chk("async_rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send_one(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h00005);
        chk_word("post_rst", 32'h0050_0093, BASE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
